imem_responder: RTL and testbench

//  Instruction-memory responder serving the fetch stage's read requests. Accepts

---
 rtl/imem_responder.sv | 207 ++++++++++++++++++++
 tb/tb_imem_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage.
// Requests are accepted over valid/ready and read from a word array with a
// registered read port. Results travel through a short flop pipeline into an
// in-order response queue whose head drives the response outputs. A preload
// port writes the program image, and flush discards all outstanding work.
module imem_responder #(
  parameter int                DWIDTH      = 32,
  parameter int                AWIDTH      = 32,
  parameter logic [AWIDTH-1:0] BASEADDR    = 32'h0100_0000,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 2,
  parameter int                RSP_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [AWIDTH-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_data_o,
  output logic [AWIDTH-1:0] rsp_addr_o,
  output logic              rsp_err_o,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [AWIDTH-1:0] wr_addr_i,
  input  logic [DWIDTH-1:0] wr_data_i
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW-1:0] RSP_DEPTH_C = CW'(RSP_DEPTH);
  localparam logic [PW-1:0] LAST_PTR    = PW'(RSP_DEPTH - 1);

  // Misaligned, below the base, or past the last word of the array.
  function automatic logic addr_bad(input logic [AWIDTH-1:0] addr);
    logic [AWIDTH-1:0] off;
    off = addr - BASEADDR;
    addr_bad = (off[1:0] != 2'b00) || (addr < BASEADDR) ||
               (off[AWIDTH-1:IW+2] != '0);
  endfunction

  // Word index relative to the base; only meaningful when addr_bad is clear.
  function automatic logic [IW-1:0] addr_idx(input logic [AWIDTH-1:0] addr);
    logic [AWIDTH-1:0] off;
    off = addr - BASEADDR;
    addr_idx = off[IW+1:2];
  endfunction

  // Circular pointer advance for the response queue.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    ptr_inc = (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  logic [DWIDTH-1:0] mem_q [DEPTH_WORDS];

  logic              accept_s;
  logic              req_err_s;
  logic [IW-1:0]     req_idx_s;
  logic              fill_valid_s;
  logic [AWIDTH-1:0] fill_addr_s;
  logic              fill_err_s;
  logic [DWIDTH-1:0] fill_data_s;
  logic              push_s;
  logic              pop_s;

  logic [DWIDTH-1:0] q_data_q [RSP_DEPTH];
  logic [AWIDTH-1:0] q_addr_q [RSP_DEPTH];
  logic              q_err_q  [RSP_DEPTH];
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     out_q;

  // Outstanding counts both pipe and queue, so the queue can never overflow.
  assign req_ready_o = !rst && !flush_i && (out_q < RSP_DEPTH_C);
  assign accept_s    = req_valid_i && req_ready_o;
  assign req_err_s   = addr_bad(req_addr_i);
  assign req_idx_s   = addr_idx(req_addr_i);
  assign push_s      = fill_valid_s && !flush_i;
  assign pop_s       = (cnt_q != '0) && rsp_ready_i;

  // Preload write port; bad addresses are silently ignored.
  always_ff @(posedge clk) begin
    if (wr_en_i && !addr_bad(wr_addr_i)) begin
      mem_q[addr_idx(wr_addr_i)] <= wr_data_i;
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      // Single-cycle latency leaves no room for a read register.
      assign fill_valid_s = accept_s;
      assign fill_addr_s  = req_addr_i;
      assign fill_err_s   = req_err_s;
      assign fill_data_s  = req_err_s ? '0 : mem_q[req_idx_s];
    end else begin : g_pipe
      logic [DWIDTH-1:0] rd_data_q;
      logic              s0_valid_q;
      logic [AWIDTH-1:0] s0_addr_q;
      logic              s0_err_q;
      logic [DWIDTH-1:0] s0_data_s;

      // Registered array read; same-cycle write is seen on the next read.
      always_ff @(posedge clk) begin
        rd_data_q <= mem_q[req_idx_s];
      end

      // Request side-band follows the array read by one cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s0_valid_q <= 1'b0;
          s0_addr_q  <= '0;
          s0_err_q   <= 1'b0;
        end else begin
          s0_valid_q <= accept_s;
          s0_addr_q  <= req_addr_i;
          s0_err_q   <= req_err_s;
        end
      end

      assign s0_data_s = s0_err_q ? '0 : rd_data_q;

      if (LATENCY == 2) begin : g_direct
        assign fill_valid_s = s0_valid_q;
        assign fill_addr_s  = s0_addr_q;
        assign fill_err_s   = s0_err_q;
        assign fill_data_s  = s0_data_s;
      end else begin : g_tail
        localparam int PT = LATENCY - 2;
        logic              t_valid_q [PT];
        logic [AWIDTH-1:0] t_addr_q  [PT];
        logic              t_err_q   [PT];
        logic [DWIDTH-1:0] t_data_q  [PT];

        // Extra latency stages; flush kills every valid bit.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            for (int k = 0; k < PT; k++) begin
              t_valid_q[k] <= 1'b0;
              t_addr_q[k]  <= '0;
              t_err_q[k]   <= 1'b0;
              t_data_q[k]  <= '0;
            end
          end else begin
            t_valid_q[0] <= s0_valid_q && !flush_i;
            t_addr_q[0]  <= s0_addr_q;
            t_err_q[0]   <= s0_err_q;
            t_data_q[0]  <= s0_data_s;
            for (int k = 1; k < PT; k++) begin
              t_valid_q[k] <= t_valid_q[k-1] && !flush_i;
              t_addr_q[k]  <= t_addr_q[k-1];
              t_err_q[k]   <= t_err_q[k-1];
              t_data_q[k]  <= t_data_q[k-1];
            end
          end
        end

        assign fill_valid_s = t_valid_q[PT-1];
        assign fill_addr_s  = t_addr_q[PT-1];
        assign fill_err_s   = t_err_q[PT-1];
        assign fill_data_s  = t_data_q[PT-1];
      end
    end
  endgenerate

  // Response queue storage; contents are only meaningful below cnt_q.
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_data_q[wptr_q] <= fill_data_s;
      q_addr_q[wptr_q] <= fill_addr_s;
      q_err_q[wptr_q]  <= fill_err_s;
    end
  end

  // Queue pointers and outstanding accounting; flush empties everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      if (push_s) begin
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop_s) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      cnt_q <= cnt_q + CW'(push_s) - CW'(pop_s);
      out_q <= out_q + CW'(accept_s) - CW'(pop_s);
    end
  end

  // Head of the queue drives the response; zeros when nothing is pending.
  assign rsp_valid_o = (cnt_q != '0);
  assign rsp_data_o  = rsp_valid_o ? q_data_q[rptr_q] : '0;
  assign rsp_addr_o  = rsp_valid_o ? q_addr_q[rptr_q] : '0;
  assign rsp_err_o   = rsp_valid_o ? q_err_q[rptr_q]  : 1'b0;

endmodule

// File: tb/tb_imem_responder.sv
// Directed testbench for imem_responder: stream, backpressure, error
// responses, flush, same-cycle read/write and mid-operation reset.
module tb_imem_responder;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [31:0] rsp_addr_o;
  logic        rsp_err_o;
  logic        flush_i;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] prog_w [4] = '{32'h0000_0013, 32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
  logic [31:0] err_a  [3] = '{32'h0100_0002, 32'h00FF_FFFC, 32'h0100_1000};

  imem_responder dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_addr_o(rsp_addr_o), .rsp_err_o(rsp_err_o), .flush_i(flush_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    #2;
    n_cmp++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", req_ready_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid_o); end
    n_cmp++; if (rsp_data_o !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", rsp_data_o); end
    n_cmp++; if (rsp_addr_o !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", rsp_addr_o); end
    n_cmp++; if (rsp_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", rsp_err_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_en_i = 1'b1; wr_addr_i = BASE + 32'(4 * i); wr_data_i = prog_w[i];
    end
    @(negedge clk);
    wr_en_i = 1'b0;
  endtask

  task automatic test_stream;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 6) begin
        n_cmp++; if (rsp_valid_o !== 1'b1) begin n_bad++; $display("FAIL stream_valid c=%0d: got %b want 1", c, rsp_valid_o); end
        n_cmp++; if (rsp_data_o !== prog_w[c-2]) begin n_bad++; $display("FAIL stream_data c=%0d: got %h want %h", c, rsp_data_o, prog_w[c-2]); end
        n_cmp++; if (rsp_addr_o !== BASE + 32'(4 * (c - 2))) begin n_bad++; $display("FAIL stream_addr c=%0d: got %h want %h", c, rsp_addr_o, BASE + 32'(4 * (c - 2))); end
        n_cmp++; if (rsp_err_o !== 1'b0) begin n_bad++; $display("FAIL stream_err c=%0d: got %b want 0", c, rsp_err_o); end
      end else begin
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL stream_idle c=%0d: got %b want 0", c, rsp_valid_o); end
      end
      if (c < 4) begin
        req_valid_i = 1'b1; req_addr_i = BASE + 32'(4 * c);
        #1;
        n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL stream_ready c=%0d: got %b want 1", c, req_ready_o); end
      end else begin
        req_valid_i = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got  = 0;
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      if (c == 6) rsp_ready_i = 1'b1;
      if (c == 4 || c == 5) begin
        n_cmp++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_full c=%0d: got %b want 0", c, req_ready_o); end
        n_cmp++; if (sent !== 4) begin n_bad++; $display("FAIL bp_accepted c=%0d: got %0d want 4", c, sent); end
      end
      if (c == 5) begin
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== prog_w[0]) begin n_bad++; $display("FAIL bp_hold: got %b/%h want 1/%h", rsp_valid_o, rsp_data_o, prog_w[0]); end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        n_cmp++; if (rsp_data_o !== prog_w[got % 4] || rsp_addr_o !== BASE + 32'(4 * (got % 4))) begin
          n_bad++; $display("FAIL bp_order #%0d: got %h@%h want %h@%h", got, rsp_data_o, rsp_addr_o, prog_w[got % 4], BASE + 32'(4 * (got % 4)));
        end
        got++;
      end
      if (sent < 6) begin
        req_valid_i = 1'b1; req_addr_i = BASE + 32'(4 * (sent % 4));
        if (req_ready_o) sent++;
      end else begin
        req_valid_i = 1'b0;
      end
    end
    req_valid_i = 1'b0;
    n_cmp++; if (got !== 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", got); end
    @(negedge clk);
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_errors;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 5) begin
        n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin n_bad++; $display("FAIL err_flag c=%0d: got v%b e%b want v1 e1", c, rsp_valid_o, rsp_err_o); end
        n_cmp++; if (rsp_data_o !== 32'h0) begin n_bad++; $display("FAIL err_data c=%0d: got %h want 0", c, rsp_data_o); end
        n_cmp++; if (rsp_addr_o !== err_a[c-2]) begin n_bad++; $display("FAIL err_addr c=%0d: got %h want %h", c, rsp_addr_o, err_a[c-2]); end
      end
      if (c == 5) begin
        n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL err_idle: got %b want 0", rsp_valid_o); end
      end
      if (c < 3) begin
        req_valid_i = 1'b1; req_addr_i = err_a[c];
      end else begin
        req_valid_i = 1'b0;
      end
    end
  endtask

  task automatic test_flush;
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      case (c)
        0: begin req_valid_i = 1'b1; req_addr_i = BASE; end
        1: req_addr_i = BASE + 32'h8;
        2: req_addr_i = BASE + 32'hC;
        3: begin
          flush_i = 1'b1; req_addr_i = BASE + 32'h4;
          #1;
          n_cmp++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", req_ready_o); end
        end
        4: begin
          flush_i = 1'b0; rsp_ready_i = 1'b1;
          n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_gone c4: got %b want 0", rsp_valid_o); end
          #1;
          n_cmp++; if (req_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_resume: got %b want 1", req_ready_o); end
        end
        5: begin
          req_valid_i = 1'b0;
          n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_gone c5: got %b want 0", rsp_valid_o); end
        end
        6: begin
          n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h0050_0093 || rsp_addr_o !== BASE + 32'h4) begin
            n_bad++; $display("FAIL flush_new: got %b %h@%h want 1 00500093@%h", rsp_valid_o, rsp_data_o, rsp_addr_o, BASE + 32'h4);
          end
        end
        default: begin
          n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_after c=%0d: got %b want 0", c, rsp_valid_o); end
        end
      endcase
    end
  endtask

  task automatic test_same_cycle;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    wr_en_i = 1'b1; wr_addr_i = BASE + 32'h8; wr_data_i = 32'hDEAD_BEEF;
    req_valid_i = 1'b1; req_addr_i = BASE + 32'h8;
    @(negedge clk);
    wr_en_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b0;
    n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h00A0_0113) begin n_bad++; $display("FAIL rw_old: got %b %h want 1 00a00113", rsp_valid_o, rsp_data_o); end
    @(negedge clk);
    n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rw_new: got %b %h want 1 deadbeef", rsp_valid_o, rsp_data_o); end
    @(negedge clk);
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL rw_idle: got %b want 0", rsp_valid_o); end
  endtask

  task automatic test_reset_mid;
    rsp_ready_i = 1'b0;
    @(negedge clk);
    req_valid_i = 1'b1; req_addr_i = BASE;
    @(negedge clk);
    req_addr_i = BASE + 32'h4;
    @(negedge clk);
    req_valid_i = 1'b0; rst = 1'b1;
    #1;
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got %b want 0", rsp_valid_o); end
    n_cmp++; if (req_ready_o !== 1'b0) begin n_bad++; $display("FAIL mrst_ready: got %b want 0", req_ready_o); end
    @(negedge clk);
    rst = 1'b0; rsp_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL mrst_stale c=%0d: got %b want 0", c, rsp_valid_o); end
    end
    req_valid_i = 1'b1; req_addr_i = BASE + 32'hC;
    @(negedge clk);
    req_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h0020_81B3) begin n_bad++; $display("FAIL mrst_mem: got %b %h want 1 002081b3", rsp_valid_o, rsp_data_o); end
    @(negedge clk);
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL mrst_idle: got %b want 0", rsp_valid_o); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    req_valid_i = 1'b0; req_addr_i = 32'h0; rsp_ready_i = 1'b0; flush_i = 1'b0;
    wr_en_i = 1'b0; wr_addr_i = 32'h0; wr_data_i = 32'h0;
    test_reset;
    preload;
    test_stream;
    test_backpressure;
    test_errors;
    test_flush;
    test_same_cycle;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
